stack_seq_ctrl: RTL and testbench
=================================

Name: stack_seq_ctrl

Overview:
- Multi-cycle sequencer in the decode stage, directly upstream of the decode/execute pipeline register.
- Expands CALL, RET, RTI and external interrupts into per-cycle 16-bit stack push/pop steps.
- Drives the enablePushOrPop, firstTimeCall, firstTimeRET and firstTimeINT fields that the pipeline register carries to execute/memory.
- Holds fetch/decode and injects bubbles while a sequence runs.

Parameters:
DEPTH_W, 11, width of the optional stack-depth counter (words).

Ports:
clk  in  1  pipeline clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
opValid  in  1  decoded instruction in decode is valid.
isCall  in  1  decoded op is CALL.
isRet  in  1  decoded op is RET.
isRti  in  1  decoded op is RTI.
intReq  in  1  external interrupt request, level.
flush  in  1  branch flush from execute.
stallIn  in  1  hazard-unit stall; freezes this block.
enablePushOrPop  out  2  00 none, 01 push, 10 pop.
firstTimeCall  out  2  CALL step code.
firstTimeRET  out  2  RET/RTI step code.
firstTimeINT  out  2  INT step code.
decHold  out  1  hold PC and fetch/decode register.
bubble  out  1  force non-sequence control fields to NOP in the decode/execute register.
intAck  out  1  one-cycle interrupt acknowledge.
busy  out  1  FSM not IDLE.

Behaviour:
- All outputs are registered (Moore, from state). Reset value of every output is 0 and state is IDLE. Reset mid-sequence aborts immediately.
- States: IDLE, CALL_HI, CALL_LO, RET_LO, RET_HI, RTI_LO, RTI_HI, RTI_FL, INT_FL, INT_HI, INT_LO.
- Step codes: 01 first word, 10 second word, 11 flags word, 00 idle.
- IDLE acceptance priority, highest first:
  - flush: stay IDLE, drop the op.
  - intReq (or pending latch): go to INT_FL.
  - opValid & isCall: go to CALL_HI.
  - opValid & isRet: go to RET_LO.
  - opValid & isRti: go to RTI_LO.
  - Otherwise stay IDLE.
- Sequences and outputs per state:
  - CALL_HI: push, firstTimeCall=01 (PC[31:16]). CALL_LO: push, firstTimeCall=10 (PC[15:0]). Then IDLE.
  - RET_LO: pop, firstTimeRET=01. RET_HI: pop, firstTimeRET=10. Then IDLE.
  - RTI_LO: pop, 01. RTI_HI: pop, 10. RTI_FL: pop, 11. Then IDLE.
  - INT_FL: push, firstTimeINT=11. INT_HI: push, 01. INT_LO: push, 10; intAck=1 in this cycle only. Then IDLE.
- Latency: the first step appears 1 cycle after acceptance.
- decHold=1 and busy=1 in every non-IDLE state. bubble=1 in every non-IDLE state except CALL_HI, RET_LO and RTI_LO, which carry the accepted instruction itself.
- stallIn=1: state and all outputs frozen. Takes precedence over everything except reset.
- flush=1 in any CALL/RET/RTI state: next state IDLE, outputs 0 next cycle. flush has no effect in INT states.
- intReq while busy: set a pending latch, cleared on entry to INT_FL. intReq held high through INT_LO does not re-trigger; the latch is only set on a 0->1 edge of intReq.
- Back-to-back: IDLE is always visited for at least 1 cycle between sequences.

Optional Feature:
STACK_DEPTH_EN
- Defined: adds outputs stackDepth[DEPTH_W-1:0] and stackUnderflow (1 bit), both reset to 0.
  - stackDepth increments on each push step and decrements on each pop step.
  - It saturates at all-ones; it is not decremented below 0.
  - A pop with depth 0 sets stackUnderflow, which is sticky until reset.
  - stallIn freezes both outputs.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid CALL_LO (rst_n low 1 cycle) -> all outputs 0 asynchronously; state IDLE; next isCall restarts at CALL_HI.
- isCall pulse at cycle 0 -> cycle 1 push/firstTimeCall=01/bubble=0; cycle 2 push/10/bubble=1; cycle 3 all 0; decHold=1 in cycles 1-2.
- isRti -> pops with codes 01, 10, 11 over 3 cycles; stallIn=1 for 2 cycles during RTI_HI -> RTI_HI outputs held, then RTI_FL.
- intReq rises during RET_LO -> RET completes; 1 IDLE cycle; then INT steps 11, 01, 10; intAck=1 only in the INT_LO cycle.
- flush with isCall in IDLE -> no sequence. flush during CALL_HI -> outputs 0 the next cycle. flush during INT_HI -> INT completes.
- STACK_DEPTH_EN: CALL then RET -> stackDepth 0, 1, 2, 1, 0. RET from depth 0 -> stackUnderflow=1, stackDepth stays 0.

Source files
------------

// File: rtl/stack_seq_ctrl.sv
// Decode-stage sequencer that expands CALL, RET, RTI and interrupts into 16-bit stack push/pop steps.
// Build option STACK_DEPTH_EN adds the stackDepth/stackUnderflow tracking outputs.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   S_IDLE    | no sequence; accepting flush/interrupt/CALL/RET/RTI
//   S_CALL_HI | push PC[31:16], carries the CALL itself
//   S_CALL_LO | push PC[15:0]
//   S_RET_LO  | pop low word, carries the RET itself
//   S_RET_HI  | pop high word
//   S_RTI_LO  | pop low word, carries the RTI itself
//   S_RTI_HI  | pop high word
//   S_RTI_FL  | pop flags word
//   S_INT_FL  | push flags word
//   S_INT_HI  | push PC high word
//   S_INT_LO  | push PC low word, acknowledge interrupt
module stack_seq_ctrl #(
    parameter int DEPTH_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               opValid,
    input  logic               isCall,
    input  logic               isRet,
    input  logic               isRti,
    input  logic               intReq,
    input  logic               flush,
    input  logic               stallIn,
    output logic [1:0]         enablePushOrPop,
    output logic [1:0]         firstTimeCall,
    output logic [1:0]         firstTimeRET,
    output logic [1:0]         firstTimeINT,
    output logic               decHold,
    output logic               bubble,
    output logic               intAck,
`ifdef STACK_DEPTH_EN
    output logic               busy,
    output logic [DEPTH_W-1:0] stackDepth,
    output logic               stackUnderflow
`else
    output logic               busy
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CALL_HI,
        S_CALL_LO,
        S_RET_LO,
        S_RET_HI,
        S_RTI_LO,
        S_RTI_HI,
        S_RTI_FL,
        S_INT_FL,
        S_INT_HI,
        S_INT_LO
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] STEP_1  = 2'b01;
    localparam logic [1:0] STEP_2  = 2'b10;
    localparam logic [1:0] STEP_FL = 2'b11;

    state_t     r_state;
    state_t     w_next;

    logic       r_int_prev;
    logic       r_int_pend;
    logic       w_int_edge;
    logic       w_int_take;

    logic [1:0] r_pp;
    logic [1:0] r_call;
    logic [1:0] r_ret;
    logic [1:0] r_intc;
    logic       r_bubble;
    logic       r_ack;
    logic       r_busy;

    logic [1:0] w_pp;
    logic [1:0] w_call;
    logic [1:0] w_ret;
    logic [1:0] w_intc;
    logic       w_bubble;
    logic       w_ack;
    logic       w_busy;

    // Only a fresh rising edge arms an interrupt, so a level held through INT_LO cannot re-enter
    assign w_int_edge = intReq & ~r_int_prev;

    always_comb begin
        w_next     = r_state;
        w_int_take = 1'b0;
        if (!stallIn) begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        w_next = S_IDLE;
                    end else if (r_int_pend || w_int_edge) begin
                        w_next     = S_INT_FL;
                        w_int_take = 1'b1;
                    end else if (opValid && isCall) begin
                        w_next = S_CALL_HI;
                    end else if (opValid && isRet) begin
                        w_next = S_RET_LO;
                    end else if (opValid && isRti) begin
                        w_next = S_RTI_LO;
                    end
                end
                S_CALL_HI: w_next = flush ? S_IDLE : S_CALL_LO;
                S_CALL_LO: w_next = S_IDLE;
                S_RET_LO:  w_next = flush ? S_IDLE : S_RET_HI;
                S_RET_HI:  w_next = S_IDLE;
                S_RTI_LO:  w_next = flush ? S_IDLE : S_RTI_HI;
                S_RTI_HI:  w_next = flush ? S_IDLE : S_RTI_FL;
                S_RTI_FL:  w_next = S_IDLE;
                S_INT_FL:  w_next = S_INT_HI;
                S_INT_HI:  w_next = S_INT_LO;
                S_INT_LO:  w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered alongside it
    always_comb begin
        w_pp   = 2'b00;
        w_call = 2'b00;
        w_ret  = 2'b00;
        w_intc = 2'b00;
        w_ack  = 1'b0;
        w_busy = (w_next != S_IDLE);
        case (w_next)
            S_CALL_HI: begin w_pp = OP_PUSH; w_call = STEP_1;  end
            S_CALL_LO: begin w_pp = OP_PUSH; w_call = STEP_2;  end
            S_RET_LO:  begin w_pp = OP_POP;  w_ret  = STEP_1;  end
            S_RET_HI:  begin w_pp = OP_POP;  w_ret  = STEP_2;  end
            S_RTI_LO:  begin w_pp = OP_POP;  w_ret  = STEP_1;  end
            S_RTI_HI:  begin w_pp = OP_POP;  w_ret  = STEP_2;  end
            S_RTI_FL:  begin w_pp = OP_POP;  w_ret  = STEP_FL; end
            S_INT_FL:  begin w_pp = OP_PUSH; w_intc = STEP_FL; end
            S_INT_HI:  begin w_pp = OP_PUSH; w_intc = STEP_1;  end
            S_INT_LO:  begin w_pp = OP_PUSH; w_intc = STEP_2; w_ack = 1'b1; end
            default:   ;
        endcase
        // The first step of CALL/RET/RTI still carries the accepted instruction down the pipe
        w_bubble = w_busy && !(w_next inside {S_CALL_HI, S_RET_LO, S_RTI_LO});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pp     <= 2'b00;
            r_call   <= 2'b00;
            r_ret    <= 2'b00;
            r_intc   <= 2'b00;
            r_bubble <= 1'b0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_pp     <= w_pp;
            r_call   <= w_call;
            r_ret    <= w_ret;
            r_intc   <= w_intc;
            r_bubble <= w_bubble;
            r_ack    <= w_ack;
            r_busy   <= w_busy;
        end
    end

    // Edges seen while stalled or busy are remembered until the sequence can start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_prev <= 1'b0;
            r_int_pend <= 1'b0;
        end else begin
            r_int_prev <= intReq;
            if (w_int_take) begin
                r_int_pend <= 1'b0;
            end else if (w_int_edge) begin
                r_int_pend <= 1'b1;
            end
        end
    end

    assign enablePushOrPop = r_pp;
    assign firstTimeCall   = r_call;
    assign firstTimeRET    = r_ret;
    assign firstTimeINT    = r_intc;
    assign decHold         = r_busy;
    assign busy            = r_busy;
    assign bubble          = r_bubble;
    assign intAck          = r_ack;

`ifdef STACK_DEPTH_EN
    logic [DEPTH_W-1:0] r_depth;
    logic               r_underflow;

    // Every non-stalled cycle that lands in a push/pop state is exactly one new stack step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth     <= '0;
            r_underflow <= 1'b0;
        end else if (!stallIn) begin
            if (w_pp == OP_PUSH) begin
                if (r_depth != '1) begin
                    r_depth <= r_depth + 1'b1;
                end
            end else if (w_pp == OP_POP) begin
                if (r_depth == '0) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_depth <= r_depth - 1'b1;
                end
            end
        end
    end

    assign stackDepth     = r_depth;
    assign stackUnderflow = r_underflow;
`endif

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Bench for stack_seq_ctrl: a queue-of-steps reference model compared every cycle, plus literal pins.
// Depth/underflow checks are active when STACK_DEPTH_EN is defined.
module tb_stack_seq_ctrl;

    localparam int DW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic opValid = 1'b0, isCall = 1'b0, isRet = 1'b0, isRti = 1'b0;
    logic intReq = 1'b0, flush = 1'b0, stallIn = 1'b0;
    logic [1:0] enablePushOrPop, firstTimeCall, firstTimeRET, firstTimeINT;
    logic decHold, bubble, intAck, busy;
`ifdef STACK_DEPTH_EN
    logic [DW-1:0] stackDepth;
    logic          stackUnderflow;
`endif

    stack_seq_ctrl #(.DEPTH_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .opValid(opValid), .isCall(isCall), .isRet(isRet),
        .isRti(isRti), .intReq(intReq), .flush(flush), .stallIn(stallIn),
        .enablePushOrPop(enablePushOrPop), .firstTimeCall(firstTimeCall),
        .firstTimeRET(firstTimeRET), .firstTimeINT(firstTimeINT), .decHold(decHold),
        .bubble(bubble), .intAck(intAck),
`ifdef STACK_DEPTH_EN
        .busy(busy), .stackDepth(stackDepth), .stackUnderflow(stackUnderflow)
`else
        .busy(busy)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [11:0] b;
    assign b = {enablePushOrPop, firstTimeCall, firstTimeRET, firstTimeINT,
                decHold, bubble, intAck, busy};

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] pp, call, ret, intc;
        logic bub, ack, is_int;
    } step_t;

    function automatic step_t mk(logic [1:0] pp, c, r, i, logic bub, ack, isi);
        step_t s;
        s.pp = pp; s.call = c; s.ret = r; s.intc = i; s.bub = bub; s.ack = ack; s.is_int = isi;
        return s;
    endfunction

    step_t q[$];
    step_t m_cur = '0;
    bit    m_valid = 1'b0;
    bit    m_prev = 1'b0;
    bit    m_pend = 1'b0;
    int    m_depth = 0;
    bit    m_uf = 1'b0;

    function automatic logic [11:0] expb();
        if (!m_valid) return 12'h000;
        return {m_cur.pp, m_cur.call, m_cur.ret, m_cur.intc, 1'b1, m_cur.bub, m_cur.ack, 1'b1};
    endfunction

    initial forever begin
        bit edge_i, took;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete(); m_valid = 0; m_cur = '0; m_prev = 0; m_pend = 0; m_depth = 0; m_uf = 0;
        end else begin
            edge_i = intReq && !m_prev;
            m_prev = intReq;
            took = 0;
            if (stallIn) begin
                if (edge_i) m_pend = 1;
            end else begin
                if (m_valid) begin
                    if (flush && !m_cur.is_int) begin
                        m_valid = 0; q.delete();
                    end else if (q.size() > 0) begin
                        m_cur = q.pop_front();
                    end else begin
                        m_valid = 0;
                    end
                end else if (!flush) begin
                    if (m_pend || edge_i) begin
                        took = 1;
                        m_cur = mk(2'b01, 0, 0, 2'b11, 1, 0, 1);
                        q.push_back(mk(2'b01, 0, 0, 2'b01, 1, 0, 1));
                        q.push_back(mk(2'b01, 0, 0, 2'b10, 1, 1, 1));
                        m_valid = 1;
                    end else if (opValid && isCall) begin
                        m_cur = mk(2'b01, 2'b01, 0, 0, 0, 0, 0);
                        q.push_back(mk(2'b01, 2'b10, 0, 0, 1, 0, 0));
                        m_valid = 1;
                    end else if (opValid && isRet) begin
                        m_cur = mk(2'b10, 0, 2'b01, 0, 0, 0, 0);
                        q.push_back(mk(2'b10, 0, 2'b10, 0, 1, 0, 0));
                        m_valid = 1;
                    end else if (opValid && isRti) begin
                        m_cur = mk(2'b10, 0, 2'b01, 0, 0, 0, 0);
                        q.push_back(mk(2'b10, 0, 2'b10, 0, 1, 0, 0));
                        q.push_back(mk(2'b10, 0, 2'b11, 0, 1, 0, 0));
                        m_valid = 1;
                    end
                end
                if (took) m_pend = 0;
                else if (edge_i) m_pend = 1;
                if (m_valid && m_cur.pp == 2'b01) begin
                    if (m_depth < (1 << DW) - 1) m_depth++;
                end else if (m_valid && m_cur.pp == 2'b10) begin
                    if (m_depth == 0) m_uf = 1;
                    else m_depth--;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            n_cmp++;
            if (b !== expb()) begin
                n_bad++;
                $display("FAIL outs t=%0t got %h want %h", $time, b, expb());
            end
`ifdef STACK_DEPTH_EN
            n_cmp++;
            if ({stackUnderflow, stackDepth} !== {m_uf, DW'(m_depth)}) begin
                n_bad++;
                $display("FAIL depth t=%0t got uf=%0d d=%0d want uf=%0d d=%0d",
                         $time, stackUnderflow, stackDepth, m_uf, m_depth);
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] pk(logic [1:0] pp, c, r, i, logic bub, ack);
        return {4'h0, pp, c, r, i, 1'b1, bub, ack, 1'b1};
    endfunction

    task automatic cyc(input logic ov, c, r, ti, ir, fl, st);
        opValid = ov; isCall = c; isRet = r; isRti = ti; intReq = ir; flush = fl; stallIn = st;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset", {4'h0, b}, 16'h0000);

        // CALL then RET
        cyc(1, 1, 0, 0, 0, 0, 0); chk("call_hi", {4'h0, b}, pk(1, 1, 0, 0, 0, 0));
`ifdef STACK_DEPTH_EN
        chk("depth1", {5'h0, stackDepth}, 16'd1);
`endif
        idle();                   chk("call_lo", {4'h0, b}, pk(1, 2, 0, 0, 1, 0));
`ifdef STACK_DEPTH_EN
        chk("depth2", {5'h0, stackDepth}, 16'd2);
`endif
        idle();                   chk("call_end", {4'h0, b}, 16'h0000);
        cyc(1, 0, 1, 0, 0, 0, 0); chk("ret_lo", {4'h0, b}, pk(2, 0, 1, 0, 0, 0));
        idle();                   chk("ret_hi", {4'h0, b}, pk(2, 0, 2, 0, 1, 0));
`ifdef STACK_DEPTH_EN
        chk("depth0", {5'h0, stackDepth}, 16'd0);
`endif
        idle();

        // RET from empty stack
        cyc(1, 0, 1, 0, 0, 0, 0);
`ifdef STACK_DEPTH_EN
        chk("underflow", {4'h0, stackUnderflow, stackDepth}, 16'h0800);
`endif
        idle(); idle();

        // RTI with a two-cycle stall in RTI_HI
        cyc(1, 0, 0, 1, 0, 0, 0); chk("rti_lo", {4'h0, b}, pk(2, 0, 1, 0, 0, 0));
        idle();                   chk("rti_hi", {4'h0, b}, pk(2, 0, 2, 0, 1, 0));
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1); chk("rti_stall", {4'h0, b}, pk(2, 0, 2, 0, 1, 0));
        idle();                   chk("rti_fl", {4'h0, b}, pk(2, 0, 3, 0, 1, 0));
        idle();                   chk("rti_end", {4'h0, b}, 16'h0000);

        // async reset in CALL_LO
        cyc(1, 1, 0, 0, 0, 0, 0);
        idle();
        rst_n = 1'b0;
        #1 chk("async_rst", {4'h0, b}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, 0, 0, 0, 0, 0); chk("call_restart", {4'h0, b}, pk(1, 1, 0, 0, 0, 0));
        idle(); idle();

        // interrupt rising during RET_LO, held high afterwards
        cyc(1, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0); chk("ret_hi_pend", {4'h0, b}, pk(2, 0, 2, 0, 1, 0));
        cyc(0, 0, 0, 0, 1, 0, 0); chk("gap_idle", {4'h0, b}, 16'h0000);
        cyc(0, 0, 0, 0, 1, 0, 0); chk("int_fl", {4'h0, b}, pk(1, 0, 0, 3, 1, 0));
        cyc(0, 0, 0, 0, 1, 0, 0); chk("int_hi", {4'h0, b}, pk(1, 0, 0, 1, 1, 0));
        cyc(0, 0, 0, 0, 1, 0, 0); chk("int_lo", {4'h0, b}, pk(1, 0, 0, 2, 1, 1));
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0); chk("no_retrig", {4'h0, b}, 16'h0000);
        idle();

        // flush cases
        cyc(1, 1, 0, 0, 0, 1, 0); chk("flush_idle", {4'h0, b}, 16'h0000);
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0); chk("flush_call", {4'h0, b}, 16'h0000);
        idle();
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0); chk("flush_int", {4'h0, b}, pk(1, 0, 0, 2, 1, 1));
        idle();

        // interrupt beats CALL; stalled CALL in IDLE
        cyc(1, 1, 0, 0, 1, 0, 0); chk("int_prio", {4'h0, b}, pk(1, 0, 0, 3, 1, 0));
        idle(); idle(); idle();
        cyc(1, 1, 0, 0, 0, 0, 1); chk("stall_idle", {4'h0, b}, 16'h0000);
        cyc(1, 1, 0, 0, 0, 0, 0); chk("call_after_stall", {4'h0, b}, pk(1, 1, 0, 0, 0, 0));
        idle(); idle();

        // mixed stimulus checked by the model
        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(0, 2);
            cyc($urandom_range(0, 1), k == 0, k == 1, k == 2,
                $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end
        repeat (4) idle();

`ifdef STACK_DEPTH_EN
        for (int i = 0; i < 1100; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 0);
            idle(); idle();
        end
        chk("depth_sat", {5'h0, stackDepth}, 16'h07FF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
